// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer driving one shared ALU for 32 cycles per operation.
// Define MULDIV_DIV_EN to build the divide datapath; without it DIVU completes at once with zero results.
package muldiv_pkg;
  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUBU = 6'h23;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;
endpackage

module muldiv_alu
  import muldiv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  always_comb begin
    case (funct)
      ALU_ADDU: y = a + b;
      ALU_SUBU: y = a - b;
      ALU_SLL:  y = b << shamt;
      default:  y = a;
    endcase
  end
endmodule

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] alu_a, alu_y;
  logic [5:0]  alu_funct;
  logic        carry;
`ifdef MULDIV_DIV_EN
  logic        op_q, op_d;
  logic        top, take;
  logic [31:0] rem;
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_d = S_RUN;
`else
          state_d = op ? S_DONE : S_RUN;
`endif
        end
      end
      S_RUN:   if (cnt_q == 5'(ITER - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // The ALU is shared: add for the multiply step, subtract for the divide step.
`ifdef MULDIV_DIV_EN
  assign rem       = {hi_q[30:0], lo_q[31]};
  assign top       = hi_q[31];
  assign alu_a     = op_q ? rem : hi_q;
  assign alu_funct = op_q ? ALU_SUBU : ALU_ADDU;
  assign take      = top | (rem >= opnd_q);
`else
  assign alu_a     = hi_q;
  assign alu_funct = ALU_ADDU;
`endif
  assign carry = (alu_y < hi_q);

  muldiv_alu u_alu (
    .a     (alu_a),
    .b     (opnd_q),
    .funct (alu_funct),
    .shamt (5'd0),
    .y     (alu_y)
  );

  // NOTE: every datapath next-state gets a hold default first so no latch is inferred.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
`ifdef MULDIV_DIV_EN
    op_d   = op_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hi_d  = '0;
          cnt_d = '0;
`ifdef MULDIV_DIV_EN
          op_d   = op;
          lo_d   = op ? a : b;
          opnd_d = op ? b : a;
`else
          lo_d   = op ? 32'd0 : b;
          opnd_d = op ? 32'd0 : a;
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
        if (op_q) begin
          hi_d = take ? alu_y : rem;
          lo_d = {lo_q[30:0], take};
        end else
`endif
        begin
          if (lo_q[0]) {hi_d, lo_d} = {carry, alu_y, lo_q[31:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
`ifdef MULDIV_DIV_EN
      op_q   <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
`ifdef MULDIV_DIV_EN
      op_q   <= op_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed MULTU/DIVU vectors, ignored starts, mid-run reset.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic busy_chk = 1'b0;

  localparam int MUL_LAT = 33;
`ifdef MULDIV_DIV_EN
  localparam int DIV_LAT = 33;
  localparam bit DIV_ON  = 1'b1;
`else
  localparam int DIV_LAT = 1;
  localparam bit DIV_ON  = 1'b0;
`endif

  muldiv_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops the oldest expectation on each done pulse; busy must be low the cycle after.
  always @(negedge clk) begin
    if (busy_chk) check("busy_drop", {63'd0, busy}, 64'd0);
    busy_chk <= done;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", {32'd0, hi}, {32'd0, e.hi});
        check("lo", {32'd0, lo}, {32'd0, e.lo});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drives a one-cycle start; s is the cycle in which start is high (the accept cycle).
  task automatic issue(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input bit expect_it, output int s);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = aa; b = bb;
    s = cyc;
    if (expect_it) begin
      e.hi = eh; e.lo = el; e.cyc = s + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start_at(input int c, input logic o, input logic [31:0] aa,
                                input logic [31:0] bb);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("completion_timeout", {63'd0, busy}, 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    int s;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    issue(1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, MUL_LAT, 1'b1, s);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_lo", {32'd0, lo}, 64'h2A);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, MUL_LAT, 1'b1, s);
    wait_done();

    issue(1'b1, 32'd100, 32'd7, DIV_ON ? 32'd2 : 32'd0, DIV_ON ? 32'd14 : 32'd0,
          DIV_LAT, 1'b1, s);
    wait_done();
    issue(1'b1, 32'h8000_0000, 32'd3, DIV_ON ? 32'd2 : 32'd0,
          DIV_ON ? 32'h2AAA_AAAA : 32'd0, DIV_LAT, 1'b1, s);
    wait_done();
    issue(1'b1, 32'd5, 32'd0, DIV_ON ? 32'd5 : 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0,
          DIV_LAT, 1'b1, s);
    wait_done();

    // Starts at accept+10 and in the DONE cycle must both be dropped.
    issue(1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, MUL_LAT, 1'b1, s);
    pulse_start_at(s + 10, 1'b1, 32'd99, 32'd9);
    pulse_start_at(s + 33, 1'b0, 32'd3, 32'd3);
    wait_done();
    repeat (40) @(negedge clk);

    // Reset mid-run: everything clears at once and the lost operation never signals done.
    issue(1'b0, 32'd1000, 32'd1000, 32'd0, 32'd0, MUL_LAT, 1'b0, s);
    while (cyc < s + 15) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    issue(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT, 1'b1, s);
    wait_done();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
